// File: rtl/xain_pkg.sv
// xain_pkg: shared types and helpers for the SDRAM channel arbiter.
//   sdr_arb_state_t     - arbiter FSM states
//   SDR_ARB_MAX_CLIENTS - largest supported read-client count
//   sdr_arb_idx_w()     - width of a client index for a given client count
package xain_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } sdr_arb_state_t;

    localparam int unsigned SDR_ARB_MAX_CLIENTS = 8;

    // At least one bit, so a single-client build still has a legal index vector.
    function automatic int unsigned sdr_arb_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_ch_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin request picker with a rotating priority pointer.
//   CLK, RSTn  - clock, asynchronous active-low reset
//   req        - per-requester request vector
//   advance    - move the pointer past the current winner
//   grant      - one-hot winner (combinational)
//   grant_idx  - binary index of the winner (combinational)
//   any        - at least one request is present
module rr_arbiter
    import xain_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [N-1:0]                req,
    input  logic                        advance,
    output logic [N-1:0]                grant,
    output logic [sdr_arb_idx_w(N)-1:0] grant_idx,
    output logic                        any
);

    localparam int unsigned IdxW = sdr_arb_idx_w(N);

    logic [IdxW-1:0] ptr_q, ptr_d;
    logic            found;
    int              j;

    // Scan from the pointer upward with wrap; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < int'(N); i++) begin
            j = int'(ptr_q) + i;
            if (j >= int'(N)) begin
                j = j - int'(N);
            end
            if (!found && req[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IdxW'(j);
            end
        end
    end

    assign any = |req;

    // The winner just served drops to lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && any) begin
            ptr_d = (grant_idx == IdxW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sdram_ch_arbiter.sv
// sdram_ch_arbiter: multiplexes one ROM-download write port and NUM_CLIENTS read
// clients onto a single req/ready SDRAM channel.
//   CLK, RSTn            - SDRAM clock, asynchronous active-low reset
//   dl_*                 - download write port; dl_active gives it exclusive access
//   cli_addr/req/rdy     - read clients (packed addresses), one-cycle rdy pulses
//   cli_dout             - registered read data, valid with the matching cli_rdy bit
//   ch_*                 - registered request side towards the SDRAM controller
//   timeout_err          - sticky watchdog flag
// Optional watchdog: define SDR_ARB_TIMEOUT_EN. Without it ISSUE waits forever
// and timeout_err is tied to 0.
module sdram_ch_arbiter
    import xain_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS    = 4,
    parameter int unsigned ADDR_W         = 24,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    // Download write port
    input  logic                          dl_active,
    input  logic [ADDR_W-1:0]             dl_addr,
    input  logic [DATA_W-1:0]             dl_data,
    input  logic [1:0]                    dl_be,
    input  logic                          dl_req,
    output logic                          dl_rdy,
    // Read clients
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr,
    input  logic [NUM_CLIENTS-1:0]        cli_req,
    output logic [NUM_CLIENTS-1:0]        cli_rdy,
    output logic [DATA_W-1:0]             cli_dout,
    // SDRAM channel
    output logic [ADDR_W-1:0]             ch_addr,
    output logic [DATA_W-1:0]             ch_din,
    output logic [1:0]                    ch_be,
    output logic                          ch_rnw,
    output logic                          ch_req,
    input  logic                          ch_ready,
    input  logic [DATA_W-1:0]             ch_dout,
    // Status
    output logic                          timeout_err
);

    localparam int unsigned IdxW = sdr_arb_idx_w(NUM_CLIENTS);

    sdr_arb_state_t state_q, state_d;

    logic                   grant_dl_q, grant_dl_d;
    logic [NUM_CLIENTS-1:0] grant_oh_q, grant_oh_d;

    logic [ADDR_W-1:0]      ch_addr_q, ch_addr_d;
    logic [DATA_W-1:0]      ch_din_q, ch_din_d;
    logic [1:0]             ch_be_q, ch_be_d;
    logic                   ch_rnw_q, ch_rnw_d;
    logic                   ch_req_q, ch_req_d;

    logic                   dl_rdy_q, dl_rdy_d;
    logic [NUM_CLIENTS-1:0] cli_rdy_q, cli_rdy_d;
    logic [DATA_W-1:0]      cli_dout_q, cli_dout_d;

    logic [NUM_CLIENTS-1:0] rr_grant;
    logic [IdxW-1:0]        rr_grant_idx;
    logic                   rr_any;
    logic                   rr_advance;

    logic                   finish;

    logic [ADDR_W-1:0]      cli_addr_arr [NUM_CLIENTS];

    for (genvar g = 0; g < int'(NUM_CLIENTS); g++) begin : g_addr_unpack
        assign cli_addr_arr[g] = cli_addr[g*ADDR_W +: ADDR_W];
    end

`ifdef SDR_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Last ISSUE cycle index; the watchdog fires after exactly TIMEOUT_CYCLES cycles.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_err_q, timeout_err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Clients are only offered to the pointer logic; the grant is committed via
    // rr_advance when a client transaction is actually launched.
    rr_arbiter #(
        .N (NUM_CLIENTS)
    ) u_rr (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .req       (cli_req),
        .advance   (rr_advance),
        .grant     (rr_grant),
        .grant_idx (rr_grant_idx),
        .any       (rr_any)
    );

    always_comb begin
        state_d    = state_q;
        grant_dl_d = grant_dl_q;
        grant_oh_d = grant_oh_q;
        ch_addr_d  = ch_addr_q;
        ch_din_d   = ch_din_q;
        ch_be_d    = ch_be_q;
        ch_rnw_d   = ch_rnw_q;
        ch_req_d   = ch_req_q;
        cli_dout_d = cli_dout_q;
        dl_rdy_d   = 1'b0;
        cli_rdy_d  = '0;
        rr_advance = 1'b0;
        finish     = 1'b0;
`ifdef SDR_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (dl_active && dl_req) begin
                    grant_dl_d = 1'b1;
                    grant_oh_d = '0;
                    ch_addr_d  = dl_addr;
                    ch_din_d   = dl_data;
                    ch_be_d    = dl_be;
                    ch_rnw_d   = 1'b0;
                    ch_req_d   = 1'b1;
                    state_d    = StIssue;
`ifdef SDR_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end else if (!dl_active && rr_any) begin
                    grant_dl_d = 1'b0;
                    grant_oh_d = rr_grant;
                    ch_addr_d  = cli_addr_arr[rr_grant_idx];
                    ch_din_d   = '0;
                    ch_be_d    = 2'b11;
                    ch_rnw_d   = 1'b1;
                    ch_req_d   = 1'b1;
                    rr_advance = 1'b1;
                    state_d    = StIssue;
`ifdef SDR_ARB_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StIssue: begin
                if (ch_ready) begin
                    cli_dout_d = ch_dout;
                    finish     = 1'b1;
                end
`ifdef SDR_ARB_TIMEOUT_EN
                else if (cnt_q == CntLast) begin
                    // Complete with poisoned data so the requester is never stuck.
                    cli_dout_d    = '1;
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // rdy is registered, so it is high exactly during the RESP cycle.
        if (finish) begin
            ch_req_d = 1'b0;
            state_d  = StResp;
            if (grant_dl_q) begin
                dl_rdy_d = 1'b1;
            end else begin
                cli_rdy_d = grant_oh_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= StIdle;
            grant_dl_q <= 1'b0;
            grant_oh_q <= '0;
            ch_addr_q  <= '0;
            ch_din_q   <= '0;
            ch_be_q    <= '0;
            ch_rnw_q   <= 1'b0;
            ch_req_q   <= 1'b0;
            dl_rdy_q   <= 1'b0;
            cli_rdy_q  <= '0;
            cli_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_dl_q <= grant_dl_d;
            grant_oh_q <= grant_oh_d;
            ch_addr_q  <= ch_addr_d;
            ch_din_q   <= ch_din_d;
            ch_be_q    <= ch_be_d;
            ch_rnw_q   <= ch_rnw_d;
            ch_req_q   <= ch_req_d;
            dl_rdy_q   <= dl_rdy_d;
            cli_rdy_q  <= cli_rdy_d;
            cli_dout_q <= cli_dout_d;
        end
    end

`ifdef SDR_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign ch_addr  = ch_addr_q;
    assign ch_din   = ch_din_q;
    assign ch_be    = ch_be_q;
    assign ch_rnw   = ch_rnw_q;
    assign ch_req   = ch_req_q;
    assign dl_rdy   = dl_rdy_q;
    assign cli_rdy  = cli_rdy_q;
    assign cli_dout = cli_dout_q;

endmodule
